spike_event_queue: RTL and testbench

Output event stage of the SNN core: captures the per-timestep spike vector from the neuron array and serializes it into neuron addresses, lowest index first. It buffers the addresses in a show-ahead FIFO and presents them on the active-low `snn_event_n` / `neuron_addr_out` / `snn_ren` read interface used by the SoC and the top-level bench. It sits directly downstream of the neuron layer and directly upstream of the external event reader.

---
 rtl/spike_event_queue.sv | 173 +++++++++++++++++
 tb/tb_spike_event_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_queue.sv
// spike_event_queue: captures a per-timestep spike vector and serializes it into
// neuron addresses (lowest index first). Addresses are buffered in a show-ahead
// FIFO and read through the active-low snn_event_n / neuron_addr_out / snn_ren
// interface.
// Optional feature macro: SPIKE_QUEUE_TIMESTAMP_EN adds an 8-bit timestep
// counter and the event_ts output. Each FIFO entry then stores {ts, addr}.
module spike_event_queue #(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 spike_valid,
  input  logic [N_NEURONS-1:0] spike_vec,
  output logic                 spike_ready,
  input  logic                 snn_ren,
  output logic                 snn_event_n,
  output logic [ADDR_W-1:0]    neuron_addr_out,
  output logic                 overflow
`ifdef SPIKE_QUEUE_TIMESTAMP_EN
  ,
  output logic [7:0]           event_ts
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef SPIKE_QUEUE_TIMESTAMP_EN
  localparam int unsigned TS_W    = 8;
  localparam int unsigned ENTRY_W = TS_W + ADDR_W;
`else
  localparam int unsigned ENTRY_W = ADDR_W;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_spike_ready;
  logic                 r_overflow;
  logic [N_NEURONS-1:0] r_pending;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic [ADDR_W-1:0]    w_low_idx;
  logic [N_NEURONS-1:0] w_pending_clr;
  logic [ENTRY_W-1:0]   w_entry;
  logic [ENTRY_W-1:0]   w_head;

`ifdef SPIKE_QUEUE_TIMESTAMP_EN
  logic [TS_W-1:0]      r_ts;
  logic [TS_W-1:0]      r_pending_ts;
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = snn_ren && !w_empty;
  assign w_head  = r_mem[r_rptr];

  // Lowest set bit of pending is the next address to emit.
  always_comb begin
    w_low_idx = '0;
    for (int i = int'(N_NEURONS) - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = ADDR_W'(i);
    end
  end

  // Pending vector with its lowest set bit cleared.
  assign w_pending_clr = r_pending & (r_pending - N_NEURONS'(1));

`ifdef SPIKE_QUEUE_TIMESTAMP_EN
  assign w_entry = {r_pending_ts, w_low_idx};
`else
  assign w_entry = w_low_idx;
`endif

  // Serializer next-state: accept in IDLE, push one address per cycle in SCAN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = spike_valid;
        if (spike_valid && (spike_vec != '0)) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        w_push = !w_full || w_pop;
        if (w_push && (w_pending_clr == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Serializer state, ready flag and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_spike_ready <= 1'b1;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_spike_ready <= (w_state_nxt == S_IDLE);
      if (spike_valid && !r_spike_ready) r_overflow <= 1'b1;
    end
  end

  // Pending vector: load on accept, clear one bit per successful push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else if (w_accept) begin
      r_pending <= spike_vec;
    end else if (w_push) begin
      r_pending <= w_pending_clr;
    end
  end

`ifdef SPIKE_QUEUE_TIMESTAMP_EN
  // Timestep counter advances on every accepted vector; value is held with the vector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ts         <= '0;
      r_pending_ts <= '0;
    end else if (w_accept) begin
      r_ts         <= r_ts + TS_W'(1);
      r_pending_ts <= r_ts;
    end
  end
`endif

  // FIFO storage; contents are don't-care while the occupancy counter says empty.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  // FIFO pointers and occupancy; pointers wrap at DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign spike_ready     = r_spike_ready;
  assign overflow        = r_overflow;
  assign snn_event_n     = w_empty;
  assign neuron_addr_out = w_empty ? '0 : w_head[ADDR_W-1:0];
`ifdef SPIKE_QUEUE_TIMESTAMP_EN
  assign event_ts        = w_empty ? '0 : w_head[ENTRY_W-1 -: TS_W];
`endif

endmodule

// File: tb/tb_spike_event_queue.sv
// Self-checking bench for spike_event_queue: table-driven vectors with a
// scoreboard of expected addresses, plus hand-written stall/overflow/reset cases.
module tb_spike_event_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        spike_valid;
  logic [15:0] spike_vec;
  logic        spike_ready;
  logic        snn_ren;
  logic        snn_event_n;
  logic [3:0]  neuron_addr_out;
  logic        overflow;
`ifdef SPIKE_QUEUE_TIMESTAMP_EN
  logic [7:0]  event_ts;
`endif

  spike_event_queue #(
    .N_NEURONS (16),
    .ADDR_W    (4),
    .DEPTH     (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .spike_valid     (spike_valid),
    .spike_vec       (spike_vec),
    .spike_ready     (spike_ready),
    .snn_ren         (snn_ren),
    .snn_event_n     (snn_event_n),
    .neuron_addr_out (neuron_addr_out),
    .overflow        (overflow)
`ifdef SPIKE_QUEUE_TIMESTAMP_EN
    ,
    .event_ts        (event_ts)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned exp_q[$];
  int unsigned got_q[$];
  int unsigned exp_ts_q[$];
  int unsigned ts_model = 0;

  typedef struct {
    logic [15:0] vec;
    int unsigned n_set;
    int unsigned first;
    int unsigned last;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference serializer: addresses of set bits, lowest first, tagged with the timestep.
  function automatic void model_accept(input logic [15:0] v);
    for (int b = 0; b < 16; b++) begin
      if (v[b]) begin
        exp_q.push_back(b);
        exp_ts_q.push_back(ts_model);
      end
    end
    ts_model = (ts_model + 1) % 256;
  endfunction

  // Drive a vector for the coming edge; accept says whether the DUT should take it.
  task automatic offer(input logic [15:0] v, input logic accept);
    check("ready_at_offer", spike_ready, accept);
    spike_valid = 1'b1;
    spike_vec   = v;
    if (accept) model_accept(v);
  endtask

  task automatic wait_empty(input string name, input int bound);
    int c = 0;
    while ((snn_event_n !== 1'b1 || exp_q.size() != 0) && c < bound) begin
      tick();
      c++;
    end
    n_checks++;
    if (c >= bound) begin
      n_errors++;
      $display("FAIL %s: drain not finished after %0d cycles (event_n=%0b, %0d expected left), required empty",
               name, c, snn_event_n, exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    spike_valid = 1'b0;
    spike_vec   = '0;
    snn_ren     = 1'b0;
    exp_q.delete();
    exp_ts_q.delete();
    got_q.delete();
    ts_model = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Scoreboard: every pop the DUT will take at the next edge is compared here.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && snn_ren === 1'b1 && snn_event_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got addr %0d, expected no event", neuron_addr_out);
      end else begin
        check("pop_addr", neuron_addr_out, exp_q.pop_front());
`ifdef SPIKE_QUEUE_TIMESTAMP_EN
        check("pop_ts", event_ts, exp_ts_q.pop_front());
`else
        void'(exp_ts_q.pop_front());
`endif
      end
      got_q.push_back(neuron_addr_out);
    end
  end

  initial begin
    int lat;

    tbl[0] = '{16'h8421, 4, 0, 15};
    tbl[1] = '{16'h0001, 1, 0, 0};
    tbl[2] = '{16'h8000, 1, 15, 15};
    tbl[3] = '{16'h00F0, 4, 4, 7};
    tbl[4] = '{16'h0000, 0, 0, 0};
    tbl[5] = '{16'h1248, 4, 3, 12};

    // Reset state
    reset_n     = 1'b0;
    spike_valid = 1'b0;
    spike_vec   = '0;
    snn_ren     = 1'b0;
    tick();
    check("in_reset_event_n", snn_event_n, 1'b1);
    check("in_reset_ready", spike_ready, 1'b1);
    tick();
    reset_n = 1'b1;
    tick();
    check("reset_event_n", snn_event_n, 1'b1);
    check("reset_addr", neuron_addr_out, 4'd0);
    check("reset_ready", spike_ready, 1'b1);
    check("reset_overflow", overflow, 1'b0);

    // Table: each vector drained with snn_ren held high, no stalls
    for (int t = 0; t < 6; t++) begin
      got_q.delete();
      snn_ren = 1'b1;
      offer(tbl[t].vec, 1'b1);
      tick();
      spike_valid = 1'b0;
      spike_vec   = '0;
      check($sformatf("event_n_at_capture[%0d]", t), snn_event_n, 1'b1);
      lat = 0;
      while (spike_ready !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      check($sformatf("ready_latency[%0d]", t), lat, tbl[t].n_set);
      wait_empty($sformatf("drain[%0d]", t), 40);
      check($sformatf("event_count[%0d]", t), got_q.size(), tbl[t].n_set);
      if (tbl[t].n_set != 0 && got_q.size() != 0) begin
        check($sformatf("first_addr[%0d]", t), got_q[0], tbl[t].first);
        check($sformatf("last_addr[%0d]", t), got_q[got_q.size()-1], tbl[t].last);
      end
    end

    // Full-FIFO stall: 16 events into 8 entries, no reader
    got_q.delete();
    snn_ren = 1'b0;
    offer(16'hFFFF, 1'b1);
    tick();
    spike_valid = 1'b0;
    spike_vec   = '0;
    check("stall_event_n_k", snn_event_n, 1'b1);
    tick();
    check("stall_event_n_k1", snn_event_n, 1'b0);
    check("stall_head_k1", neuron_addr_out, 4'd0);
    repeat (10) tick();
    check("stall_ready", spike_ready, 1'b0);
    check("stall_head", neuron_addr_out, 4'd0);
    snn_ren = 1'b1;
    wait_empty("stall_drain", 60);
    check("stall_count", got_q.size(), 16);
    check("stall_ready_after", spike_ready, 1'b1);
    check("stall_overflow", overflow, 1'b0);

    // Overflow: second vector offered while SCAN is busy
    got_q.delete();
    snn_ren = 1'b0;
    offer(16'h8421, 1'b1);
    tick();
    spike_valid = 1'b0;
    tick();
    offer(16'h0003, 1'b0);
    tick();
    spike_valid = 1'b0;
    spike_vec   = '0;
    check("overflow_set", overflow, 1'b1);
    repeat (5) tick();
    check("overflow_sticky", overflow, 1'b1);
    check("overflow_ready", spike_ready, 1'b1);
    snn_ren = 1'b1;
    wait_empty("overflow_drain", 40);
    check("overflow_count", got_q.size(), 4);
    check("overflow_still", overflow, 1'b1);

    // Empty read after reset
    do_reset();
    check("reset_clears_overflow", overflow, 1'b0);
    snn_ren = 1'b1;
    repeat (3) tick();
    check("empty_read_event_n", snn_event_n, 1'b1);
    check("empty_read_addr", neuron_addr_out, 4'd0);
    check("empty_read_ready", spike_ready, 1'b1);

    // Mid-stream reset with three events queued
    snn_ren = 1'b0;
    offer(16'h0007, 1'b1);
    tick();
    spike_valid = 1'b0;
    spike_vec   = '0;
    repeat (4) tick();
    check("queued_event_n", snn_event_n, 1'b0);
    check("queued_head", neuron_addr_out, 4'd0);
    reset_n = 1'b0;
    #1;
    check("async_reset_event_n", snn_event_n, 1'b1);
    check("async_reset_addr", neuron_addr_out, 4'd0);
    exp_q.delete();
    exp_ts_q.delete();
    ts_model = 0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_reset_event_n", snn_event_n, 1'b1);
    check("post_reset_ready", spike_ready, 1'b1);

`ifdef SPIKE_QUEUE_TIMESTAMP_EN
    // Timestamps 0,1,2 on three single-spike vectors
    got_q.delete();
    snn_ren = 1'b0;
    for (int v = 0; v < 3; v++) begin
      logic [15:0] one;
      one = 16'h0001 << v;
      offer(one, 1'b1);
      tick();
      spike_valid = 1'b0;
      spike_vec   = '0;
      tick();
    end
    tick();
    check("ts_head", event_ts, 8'd0);
    check("ts_head_addr", neuron_addr_out, 4'd0);
    snn_ren = 1'b1;
    wait_empty("ts_drain", 20);
    check("ts_count", got_q.size(), 3);
    check("ts_empty", event_ts, 8'd0);
`endif

    snn_ren = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
